// File: rtl/reg_bank_wr.sv
// 32 x 32-bit register bank: one write port, two async read ports, $zero and $sp reset.
// Optional write-first forwarding to the read ports under REG_BANK_BYPASS_EN.
module reg_bank_wr #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int SP_IDX   = 29,
   parameter int SP_RESET = 227
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [DATA_W-1:0] SP_RST_V = DATA_W'(SP_RESET);

   logic [DATA_W-1:0] rf_q [DEPTH];
   logic              wr_en_d;

   assign wr_en_d = RegWrite && (WriteReg != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            rf_q[i] <= (i == SP_IDX) ? SP_RST_V : '0;
         end
      end else if (wr_en_d) begin
         rf_q[WriteReg] <= WriteData;
      end
   end

   // Index 0 is forced to zero on read so its storage never matters.
   always_comb begin
      ReadData1 = (ReadReg1 == '0) ? '0 : rf_q[ReadReg1];
      ReadData2 = (ReadReg2 == '0) ? '0 : rf_q[ReadReg2];
`ifdef REG_BANK_BYPASS_EN
      if (!reset && wr_en_d && (WriteReg == ReadReg1)) begin
         ReadData1 = WriteData;
      end
      if (!reset && wr_en_d && (WriteReg == ReadReg2)) begin
         ReadData2 = WriteData;
      end
`else
`endif
   end

endmodule

// File: tb/tb_reg_bank_wr.sv
// Self-checking bench for reg_bank_wr against an array model of the register file.
module tb_reg_bank_wr;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [32];

   always #5 clk = ~clk;

   reg_bank_wr dut (
      .clk       (clk),
      .reset     (reset),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2)
   );

   function automatic logic [31:0] exp_rd(input logic [4:0] ra);
      logic [31:0] v;
      v = (ra == 5'd0) ? 32'd0 : model[ra];
`ifdef REG_BANK_BYPASS_EN
      if (!reset && RegWrite && WriteReg != 5'd0 && WriteReg == ra) v = WriteData;
`endif
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'd0;
   endtask

   // One rising edge; the model applies the architectural write rule.
   task automatic clk_edge();
      @(posedge clk);
      if (!reset && RegWrite && WriteReg != 5'd0) model[WriteReg] = WriteData;
      #1;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      RegWrite = 1'b1; WriteReg = a; WriteData = d;
      clk_edge();
      @(negedge clk);
      RegWrite = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      RegWrite = 1'b0;
      for (int i = 0; i < 32; i++) begin
         ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
         #1;
         total++;
         if (ReadData1 !== exp_rd(ReadReg1)) begin
            bad++;
            $display("FAIL reset_rd1 idx=%0d got=%h exp=%h", i, ReadData1, exp_rd(ReadReg1));
         end
         total++;
         if (ReadData2 !== exp_rd(ReadReg2)) begin
            bad++;
            $display("FAIL reset_rd2 idx=%0d got=%h exp=%h", 31 - i, ReadData2, exp_rd(ReadReg2));
         end
      end
   endtask

   task automatic test_write();
      do_write(5'd8, 32'hDEADBEEF);
      ReadReg1 = 5'd8; ReadReg2 = 5'd8;
      #1;
      total++;
      if (ReadData1 !== 32'hDEADBEEF) begin
         bad++; $display("FAIL write8_rd1 got=%h exp=deadbeef", ReadData1);
      end
      total++;
      if (ReadData2 !== 32'hDEADBEEF) begin
         bad++; $display("FAIL write8_rd2 got=%h exp=deadbeef", ReadData2);
      end
      for (int i = 0; i < 32; i++) begin
         ReadReg1 = 5'(i);
         #1;
         total++;
         if (ReadData1 !== model[i] && i != 0 || i == 0 && ReadData1 !== 32'd0) begin
            bad++;
            $display("FAIL write_others idx=%0d got=%h exp=%h", i, ReadData1, exp_rd(5'(i)));
         end
      end
   endtask

   task automatic test_zero();
      do_write(5'd0, 32'hFFFFFFFF);
      ReadReg1 = 5'd0; ReadReg2 = 5'd0;
      #1;
      total++;
      if (ReadData1 !== 32'd0) begin
         bad++; $display("FAIL zero_rd1 got=%h exp=00000000", ReadData1);
      end
      total++;
      if (ReadData2 !== 32'd0) begin
         bad++; $display("FAIL zero_rd2 got=%h exp=00000000", ReadData2);
      end
   endtask

   task automatic test_nowrite();
      @(negedge clk);
      RegWrite = 1'b0; WriteReg = 5'd5; WriteData = 32'h12345678;
      ReadReg1 = 5'd5;
      clk_edge();
      total++;
      if (ReadData1 !== 32'd0) begin
         bad++; $display("FAIL nowrite_r5 got=%h exp=00000000", ReadData1);
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] pre;
      do_write(5'd9, 32'h11);
`ifdef REG_BANK_BYPASS_EN
      pre = 32'h22;
`else
      pre = 32'h11;
`endif
      RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h22;
      ReadReg2 = 5'd9; ReadReg1 = 5'd8;
      #1;
      total++;
      if (ReadData2 !== pre) begin
         bad++; $display("FAIL same_cycle_pre got=%h exp=%h", ReadData2, pre);
      end
      total++;
      if (ReadData1 !== 32'hDEADBEEF) begin
         bad++; $display("FAIL same_cycle_other got=%h exp=deadbeef", ReadData1);
      end
      clk_edge();
      total++;
      if (ReadData2 !== 32'h22) begin
         bad++; $display("FAIL same_cycle_post got=%h exp=00000022", ReadData2);
      end
      @(negedge clk);
      RegWrite = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         RegWrite  = 1'($urandom_range(0, 1));
         WriteReg  = 5'($urandom_range(0, 31));
         WriteData = $urandom;
         ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         ReadReg2  = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         #1;
         total++;
         if (ReadData1 !== exp_rd(ReadReg1)) begin
            bad++;
            $display("FAIL rand_pre_rd1 n=%0d idx=%0d got=%h exp=%h", n, ReadReg1, ReadData1, exp_rd(ReadReg1));
         end
         total++;
         if (ReadData2 !== exp_rd(ReadReg2)) begin
            bad++;
            $display("FAIL rand_pre_rd2 n=%0d idx=%0d got=%h exp=%h", n, ReadReg2, ReadData2, exp_rd(ReadReg2));
         end
         clk_edge();
         total++;
         if (ReadData1 !== exp_rd(ReadReg1)) begin
            bad++;
            $display("FAIL rand_post_rd1 n=%0d idx=%0d got=%h exp=%h", n, ReadReg1, ReadData1, exp_rd(ReadReg1));
         end
      end
      @(negedge clk);
      RegWrite = 1'b0;
   endtask

   task automatic test_midcycle_reset();
      do_write(5'd29, 32'h100);
      do_write(5'd8, 32'hCAFEF00D);
      ReadReg1 = 5'd29;
      #1;
      total++;
      if (ReadData1 !== 32'h100) begin
         bad++; $display("FAIL sp_written got=%h exp=00000100", ReadData1);
      end
      RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'h55AA55AA;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      for (int i = 0; i < 32; i++) begin
         ReadReg1 = 5'(i); ReadReg2 = 5'(i);
         #1;
         total++;
         if (ReadData1 !== exp_rd(ReadReg1)) begin
            bad++;
            $display("FAIL midreset_rd1 idx=%0d got=%h exp=%h", i, ReadData1, exp_rd(ReadReg1));
         end
         total++;
         if (ReadData2 !== exp_rd(ReadReg2)) begin
            bad++;
            $display("FAIL midreset_rd2 idx=%0d got=%h exp=%h", i, ReadData2, exp_rd(ReadReg2));
         end
      end
      ReadReg1 = 5'd8; ReadReg2 = 5'd29;
      clk_edge();
      total++;
      if (ReadData1 !== 32'd0) begin
         bad++; $display("FAIL reset_wins_r8 got=%h exp=00000000", ReadData1);
      end
      total++;
      if (ReadData2 !== 32'd227) begin
         bad++; $display("FAIL reset_sp got=%h exp=000000e3", ReadData2);
      end
      @(negedge clk);
      RegWrite = 1'b0;
      reset = 1'b0;
      #1;
      total++;
      if (ReadData1 !== 32'd0) begin
         bad++; $display("FAIL post_reset_r8 got=%h exp=00000000", ReadData1);
      end
   endtask

   initial begin
      reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
      ReadReg1 = '0; ReadReg2 = '0;
      model_reset();
      #13;
      reset = 1'b0;
      test_reset();
      test_write();
      test_zero();
      test_nowrite();
      test_same_cycle();
      test_random();
      test_midcycle_reset();
      test_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
